// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational ALU between two requesters
//             (req0 = core datapath, req1 = auxiliary/bit-manipulation helper).
//             Round-robin arbitration with an optional lock that keeps priority
//             on the requester that just finished, valid/ready request handshake,
//             registered ALU operands and registered ALU results.
//             One operation every three cycles: accept at T, ALU evaluates at
//             T+1, rspN_valid pulses at T+2.
//  Ports    :
//    Clk, Reset                  clock, synchronous active-high reset
//    reqN_valid / reqN_ready     request handshake (N = 0, 1)
//    reqN_op/a/b/imm/sc          request fields, sampled only on the accept edge
//    reqN_lock                   keep priority on this requester after completion
//    rspN_valid                  one-cycle result pulse for requester N
//    rsp_out/zero/outbit/parity  registered ALU results (shared by both)
//    busy                        high whenever the arbiter is not IDLE
//    alu_op/a/b/imm/sc           registered operands driven to the ALU
//    alu_out/zero/outbit/parity  combinational results coming back from the ALU
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW   = 8,
    parameter int OPW  = 4,
    parameter int IMMW = 3
) (
    input  logic            Clk,
    input  logic            Reset,

    // requester 0 (core datapath)
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [IMMW-1:0] req0_imm,
    input  logic            req0_sc,
    input  logic            req0_lock,

    // requester 1 (auxiliary helper)
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_op,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [IMMW-1:0] req1_imm,
    input  logic            req1_sc,
    input  logic            req1_lock,

    // responses
    output logic            rsp0_valid,
    output logic            rsp1_valid,
    output logic [DW-1:0]   rsp_out,
    output logic            rsp_zero,
    output logic            rsp_outbit,
    output logic            rsp_parity,
    output logic            busy,

    // ALU interface
    output logic [OPW-1:0]  alu_op,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [IMMW-1:0] alu_imm,
    output logic            alu_sc,
    input  logic [DW-1:0]   alu_out,
    input  logic            alu_zero,
    input  logic            alu_outbit,
    input  logic            alu_parity
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q,      state_d;
    logic            rr_ptr_q,     rr_ptr_d;     // 0: req0 wins a tie, 1: req1 wins
    logic            gnt_id_q,     gnt_id_d;     // requester owning the op in flight
    logic            lock_q,       lock_d;       // lock bit captured with the op

    logic [OPW-1:0]  alu_op_q,     alu_op_d;
    logic [DW-1:0]   alu_a_q,      alu_a_d;
    logic [DW-1:0]   alu_b_q,      alu_b_d;
    logic [IMMW-1:0] alu_imm_q,    alu_imm_d;
    logic            alu_sc_q,     alu_sc_d;

    logic [DW-1:0]   rsp_out_q,    rsp_out_d;
    logic            rsp_zero_q,   rsp_zero_d;
    logic            rsp_outbit_q, rsp_outbit_d;
    logic            rsp_parity_q, rsp_parity_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic grant0;
    logic grant1;
    logic in_idle;
    logic accept;

    always_comb begin
        // A lone valid requester always wins; a tie goes to rr_ptr.
        grant0  = req0_valid & (~req1_valid | ~rr_ptr_q);
        grant1  = req1_valid & (~req0_valid |  rr_ptr_q);
        // Ready is suppressed while Reset is high so nothing looks accepted
        // on a cycle whose edge will discard it.
        in_idle = (state_q == ST_IDLE) & ~Reset;
        accept  = in_idle & (grant0 | grant1);
    end

    assign req0_ready = in_idle & grant0;
    assign req1_ready = in_idle & grant1;

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        lock_d       = lock_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_imm_d    = alu_imm_q;
        alu_sc_d     = alu_sc_q;
        rsp_out_d    = rsp_out_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_outbit_d = rsp_outbit_q;
        rsp_parity_d = rsp_parity_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // grant1 and grant0 are mutually exclusive; grant1 selects req1.
                    gnt_id_d = grant1;
                    if (grant1) begin
                        alu_op_d  = req1_op;
                        alu_a_d   = req1_a;
                        alu_b_d   = req1_b;
                        alu_imm_d = req1_imm;
                        alu_sc_d  = req1_sc;
                        lock_d    = req1_lock;
                    end else begin
                        alu_op_d  = req0_op;
                        alu_a_d   = req0_a;
                        alu_b_d   = req0_b;
                        alu_imm_d = req0_imm;
                        alu_sc_d  = req0_sc;
                        lock_d    = req0_lock;
                    end
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Operands have been stable on the ALU for the whole cycle.
                rsp_out_d    = alu_out;
                rsp_zero_d   = alu_zero;
                rsp_outbit_d = alu_outbit;
                rsp_parity_d = alu_parity;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                // A locked owner keeps priority; otherwise hand it to the other side.
                rr_ptr_d = lock_q ? gnt_id_q : ~gnt_id_q;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            gnt_id_q     <= 1'b0;
            lock_q       <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_imm_q    <= '0;
            alu_sc_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_outbit_q <= 1'b0;
            rsp_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            lock_q       <= lock_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_imm_q    <= alu_imm_d;
            alu_sc_q     <= alu_sc_d;
            rsp_out_q    <= rsp_out_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_outbit_q <= rsp_outbit_d;
            rsp_parity_q <= rsp_parity_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    logic in_resp;
    assign in_resp    = (state_q == ST_RESP) & ~Reset;
    assign rsp0_valid = in_resp & ~gnt_id_q;
    assign rsp1_valid = in_resp &  gnt_id_q;

    assign rsp_out    = rsp_out_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_outbit = rsp_outbit_q;
    assign rsp_parity = rsp_parity_q;
    assign busy       = (state_q != ST_IDLE);

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_imm    = alu_imm_q;
    assign alu_sc     = alu_sc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with a small behavioural ALU.
//             Table of single-requester transactions plus hand-written
//             sequences for arbitration, lock, reset abort and late valids.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LSH  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_FLIP = 4'h4;
    localparam logic [3:0] OP_CPY  = 4'h5;
    localparam logic [3:0] OP_GETB = 4'h6;
    localparam logic [3:0] OP_BXOR = 4'h7;
    localparam logic [3:0] OP_SETB = 4'h8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req0_valid, req0_ready, req0_sc, req0_lock;
    logic [3:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_imm;
    logic       req1_valid, req1_ready, req1_sc, req1_lock;
    logic [3:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_imm;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_out;
    logic       rsp_zero, rsp_outbit, rsp_parity, busy;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_imm;
    logic       alu_sc;
    logic [7:0] alu_out;
    logic       alu_zero, alu_outbit, alu_parity;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    alu_arbiter #(.DW(8), .OPW(4), .IMMW(3)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_imm   (req0_imm),
        .req0_sc    (req0_sc),
        .req0_lock  (req0_lock),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_imm   (req1_imm),
        .req1_sc    (req1_sc),
        .req1_lock  (req1_lock),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_out    (rsp_out),
        .rsp_zero   (rsp_zero),
        .rsp_outbit (rsp_outbit),
        .rsp_parity (rsp_parity),
        .busy       (busy),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_imm    (alu_imm),
        .alu_sc     (alu_sc),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_outbit (alu_outbit),
        .alu_parity (alu_parity)
    );

    // Behavioural ALU standing in for the real one.
    always_comb begin
        alu_out    = 8'h00;
        alu_outbit = 1'b0;
        case (alu_op)
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_LSH:  alu_out = {alu_a[6:0], alu_sc};
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            OP_FLIP: alu_out = ~alu_a;
            OP_CPY:  alu_out = alu_a;
            OP_GETB: begin
                alu_outbit = alu_a[alu_imm];
                alu_out    = {7'b0, alu_a[alu_imm]};
            end
            OP_BXOR: alu_out = alu_a ^ alu_b;
            OP_SETB: begin
                alu_out          = alu_a;
                alu_out[alu_imm] = alu_sc;
            end
            default: alu_out = 8'h00;
        endcase
        alu_zero   = (alu_out == 8'h00);
        alu_parity = ^alu_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int who, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] imm, input logic sc, input logic lk);
        if (who == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
            req0_imm = imm; req0_sc = sc; req0_lock = lk;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
            req1_imm = imm; req1_sc = sc; req1_lock = lk;
        end
    endtask

    typedef struct {
        int         who;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] imm;
        logic       sc;
        logic [7:0] e_out;
        logic       e_zero;
        logic       e_outbit;
        logic       e_parity;
    } vec_t;

    vec_t vecs[10];

    // One uncontended transaction starting from IDLE; checks timing and results.
    task automatic run_txn(input vec_t v, input int idx);
        string tg;
        tg = $sformatf("vec%0d", idx);
        @(negedge Clk);
        set_req(v.who, 1'b1, v.op, v.a, v.b, v.imm, v.sc, 1'b0);
        #1;
        chk({tg, " ready_own"},   (v.who == 0) ? req0_ready : req1_ready, 1);
        chk({tg, " ready_other"}, (v.who == 0) ? req1_ready : req0_ready, 0);
        chk({tg, " busy_idle"},   busy, 0);
        @(negedge Clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tg, " busy_exec"}, busy, 1);
        chk({tg, " alu_op"},  alu_op,  v.op);
        chk({tg, " alu_a"},   alu_a,   v.a);
        chk({tg, " alu_b"},   alu_b,   v.b);
        chk({tg, " alu_imm"}, alu_imm, v.imm);
        chk({tg, " alu_sc"},  alu_sc,  v.sc);
        chk({tg, " rsp_early"}, rsp0_valid | rsp1_valid, 0);
        @(negedge Clk);
        #1;
        chk({tg, " rsp0_valid"}, rsp0_valid, (v.who == 0));
        chk({tg, " rsp1_valid"}, rsp1_valid, (v.who == 1));
        chk({tg, " rsp_out"},    rsp_out,    v.e_out);
        chk({tg, " rsp_zero"},   rsp_zero,   v.e_zero);
        chk({tg, " rsp_outbit"}, rsp_outbit, v.e_outbit);
        chk({tg, " rsp_parity"}, rsp_parity, v.e_parity);
        @(negedge Clk);
        #1;
        chk({tg, " rsp_pulse_end"}, rsp0_valid | rsp1_valid, 0);
        chk({tg, " busy_done"}, busy, 0);
    endtask

    initial begin
        //          who op       a      b      imm   sc    out    z     ob    par
        vecs[0] = '{0, OP_ADD,  8'h01, 8'h01, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1, OP_SETB, 8'hB4, 8'h00, 3'd1, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1, OP_GETB, 8'h01, 8'h00, 3'd0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{0, OP_XOR,  8'hAA, 8'h55, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1, OP_ADD,  8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{0, OP_LSH,  8'h81, 8'h00, 3'd0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{0, OP_FLIP, 8'h0F, 8'h00, 3'd0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1, OP_CPY,  8'h5A, 8'h00, 3'd5, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{0, 4'hF,    8'h12, 8'h34, 3'd7, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1, OP_AND,  8'h0F, 8'h01, 3'd2, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};

        Reset = 1'b1;
        set_req(0, 1'b1, OP_ADD, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0);
        set_req(1, 1'b0, OP_ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("rst ready0_held_low", req0_ready, 0);
        Reset      = 1'b0;
        req0_valid = 1'b0;
        @(negedge Clk);
        #1;
        chk("rst busy",    busy, 0);
        chk("rst rsp_v",   {rsp0_valid, rsp1_valid}, 0);
        chk("rst rsp_out", rsp_out, 0);
        chk("rst flags",   {rsp_zero, rsp_outbit, rsp_parity}, 0);
        chk("rst alu_regs", {alu_op, alu_a, alu_b, alu_imm, alu_sc}, 0);

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // ---------------- both valid after reset: round robin ----------------
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        set_req(0, 1'b1, OP_AND,  8'h0F, 8'h01, 3'd0, 1'b0, 1'b0);
        set_req(1, 1'b1, OP_BXOR, 8'hBD, 8'h2D, 3'd0, 1'b0, 1'b0);
        #1;
        chk("rr ready0_first", req0_ready, 1);
        chk("rr ready1_first", req1_ready, 0);
        @(negedge Clk);
        #1;
        chk("rr exec_no_ready", {req0_ready, req1_ready}, 0);
        chk("rr exec_alu_op", alu_op, OP_AND);
        @(negedge Clk);
        #1;
        chk("rr rsp0_valid", rsp0_valid, 1);
        chk("rr rsp1_quiet", rsp1_valid, 0);
        chk("rr rsp_out0",   rsp_out, 8'h01);
        chk("rr resp_no_ready", {req0_ready, req1_ready}, 0);
        @(negedge Clk);
        #1;
        chk("rr ready1_second", req1_ready, 1);
        chk("rr ready0_second", req0_ready, 0);
        @(negedge Clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rr alu_op1", alu_op, OP_BXOR);
        chk("rr alu_a1",  alu_a, 8'hBD);
        @(negedge Clk);
        #1;
        chk("rr rsp1_valid", rsp1_valid, 1);
        chk("rr rsp0_quiet", rsp0_valid, 0);
        chk("rr rsp_out1",   rsp_out, 8'h90);
        @(negedge Clk);
        #1;
        chk("rr idle", {busy, rsp0_valid, rsp1_valid}, 0);

        // ---------------- lock keeps req0 in front ----------------
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1);
        set_req(1, 1'b1, OP_XOR, 8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            // lock is sampled at accept: held for the first two, released for the third
            if (g == 2) req0_lock = 1'b0;
            #1;
            chk($sformatf("lock g%0d ready0", g), req0_ready, 1);
            chk($sformatf("lock g%0d ready1", g), req1_ready, 0);
            @(negedge Clk);
            @(negedge Clk);
            #1;
            chk($sformatf("lock g%0d rsp0", g), {rsp0_valid, rsp1_valid}, 2'b10);
            chk($sformatf("lock g%0d out", g),  rsp_out, 8'h02);
            @(negedge Clk);
        end
        #1;
        chk("lock release ready1", req1_ready, 1);
        chk("lock release ready0", req0_ready, 0);
        @(negedge Clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge Clk);
        #1;
        chk("lock rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
        chk("lock out1", rsp_out, 8'hFF);
        @(negedge Clk);

        // ---------------- reset during EXEC aborts ----------------
        run_txn(vecs[3], 10);               // req0 served unlocked: rr_ptr -> 1
        @(negedge Clk);
        set_req(0, 1'b1, OP_ADD, 8'hFF, 8'h01, 3'd0, 1'b0, 1'b0);
        #1;
        chk("abort accept", req0_ready, 1);
        @(negedge Clk);
        req0_valid = 1'b0;
        Reset      = 1'b1;
        #1;
        chk("abort in_exec", busy, 1);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort busy",    busy, 0);
        chk("abort rsp_v",   {rsp0_valid, rsp1_valid}, 0);
        chk("abort rsp_out", rsp_out, 8'h00);
        chk("abort alu",     {alu_op, alu_a, alu_b}, 0);
        set_req(0, 1'b1, OP_CPY, 8'h11, 8'h00, 3'd0, 1'b0, 1'b0);
        set_req(1, 1'b1, OP_CPY, 8'h22, 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        chk("abort rr_ptr0 ready0", req0_ready, 1);
        chk("abort rr_ptr0 ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge Clk);
        #1;
        chk("abort no_late_rsp", {rsp0_valid, rsp1_valid, busy}, 0);

        // ---------------- valid during EXEC is ignored ----------------
        @(negedge Clk);
        set_req(1, 1'b1, OP_CPY, 8'h3C, 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        chk("late ready1", req1_ready, 1);
        @(negedge Clk);
        req1_valid = 1'b0;
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02, 3'd0, 1'b0, 1'b0);
        #1;
        chk("late exec ready0", req0_ready, 0);
        @(negedge Clk);
        req0_valid = 1'b0;
        #1;
        chk("late resp ready0", req0_ready, 0);
        chk("late rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
        chk("late out",  rsp_out, 8'h3C);
        @(negedge Clk);
        #1;
        chk("late idle", {busy, req0_ready}, 0);
        @(negedge Clk);
        #1;
        chk("late never_accepted", {busy, rsp0_valid, rsp1_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
